// File: rtl/tff_bank_sched.sv
// tff_bank_sched: command scheduler for an external WIDTH-bit bank of T flip-flops.
// It arbitrates two requesters round-robin and executes CLEAR / LOAD / UP n / DOWN n
// by driving the bank's t inputs. The bank's q outputs feed back on q_in.
// Ports:
//   clk, clear                   rising-edge clock; asynchronous active-high reset
//   req_a/op_a/arg_a -> ack_a    requester A command handshake (ack is a 1-cycle pulse)
//   req_b/op_b/arg_b -> ack_b    requester B command handshake
//   q_in                         current bank state
//   t_out                        bank toggle enables (combinational, nonzero only in EXEC)
//   bank_clear                   registered 1-cycle pulse to the bank's clear pin
//   busy, done                   activity flag and 1-cycle completion pulse
//   owner, wrap                  requester of last command (0=A, 1=B); boundary-crossing flag
module tff_bank_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] arg_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] arg_b,
  output logic             ack_b,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             bank_clear,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state;
  state_e           state_next;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] cnt;
  logic             prefer_b;
  logic             grant_a;
  logic             grant_b;
  logic             step;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_arg;

  // Operands of whichever requester is being granted this cycle
  assign sel_op  = grant_b ? op_e'(op_b) : op_e'(op_a);
  assign sel_arg = grant_b ? arg_b : arg_a;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, arbitration and bank toggle generation
  always_comb begin
    state_next = state;
    t_out      = '0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester not granted last wins
        if (req_a && (!req_b || !prefer_b)) grant_a = 1'b1;
        else if (req_b)                     grant_b = 1'b1;
        if (grant_a || grant_b) state_next = EXEC;
      end
      EXEC: begin
        case (cmd_op)
          OP_CLEAR: state_next = DONE;
          OP_LOAD: begin
            t_out      = q_in ^ cmd_arg;
            state_next = DONE;
          end
          OP_UP: begin
            // Bit i toggles when all lower bits are 1: exactly the bits that change on +1
            if (cnt != '0) begin
              t_out = q_in ^ (q_in + ONE);
              step  = 1'b1;
            end else begin
              state_next = DONE;
            end
          end
          OP_DOWN: begin
            // Bit i toggles when all lower bits are 0: exactly the bits that change on -1
            if (cnt != '0) begin
              t_out = q_in ^ (q_in - ONE);
              step  = 1'b1;
            end else begin
              state_next = DONE;
            end
          end
          default: state_next = DONE;
        endcase
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latches, handshake pulses and status flags
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      bank_clear <= 1'b0;
      owner      <= 1'b0;
      wrap       <= 1'b0;
      prefer_b   <= 1'b0;
      cmd_op     <= OP_CLEAR;
      cmd_arg    <= '0;
      cnt        <= '0;
    end else begin
      ack_a      <= grant_a;
      ack_b      <= grant_b;
      // Raised at the grant edge so the pulse lines up with the single CLEAR EXEC cycle
      bank_clear <= (grant_a || grant_b) && (sel_op == OP_CLEAR);
      if (grant_a || grant_b) begin
        cmd_op   <= sel_op;
        cmd_arg  <= sel_arg;
        cnt      <= sel_arg;
        owner    <= grant_b;
        wrap     <= 1'b0;
        prefer_b <= grant_a;
      end else if (step) begin
        cnt <= cnt - ONE;
        if ((cmd_op == OP_UP   && q_in == ALL_ONES) ||
            (cmd_op == OP_DOWN && q_in == '0))
          wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tff_bank_sched.sv
// Self-checking bench for tff_bank_sched: models the external tff bank, drives directed and
// random commands, and compares against an integer-level model of the bank value.
module tb_tff_bank_sched;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             req_a = 1'b0;
  logic [1:0]       op_a = 2'b00;
  logic [WIDTH-1:0] arg_a = '0;
  logic             ack_a;
  logic             req_b = 1'b0;
  logic [1:0]       op_b = 2'b00;
  logic [WIDTH-1:0] arg_b = '0;
  logic             ack_b;
  logic [WIDTH-1:0] q_bank = '0;
  logic [WIDTH-1:0] t_out;
  logic             bank_clear;
  logic             busy;
  logic             done;
  logic             owner;
  logic             wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bank value as a plain integer, and who wins the next contention
  int unsigned model_q = 0;
  bit          favour_b = 1'b0;

  tff_bank_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clear(clear),
    .req_a(req_a), .op_a(op_a), .arg_a(arg_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .arg_b(arg_b), .ack_b(ack_b),
    .q_in(q_bank), .t_out(t_out), .bank_clear(bank_clear),
    .busy(busy), .done(done), .owner(owner), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // External tff bank: each bit toggles when its t is set; clear pin zeroes it
  always @(posedge clk) begin
    if (bank_clear) q_bank <= '0;
    else            q_bank <= q_bank ^ t_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Continuous invariants
  always @(negedge clk) begin
    check("ack_exclusive", 32'(ack_a & ack_b), 0);
    if (!busy) check("t_zero_when_idle", 32'(t_out), 0);
  end

  task automatic set_req(input bit b, input logic [1:0] op, input logic [WIDTH-1:0] arg);
    if (b) begin req_b = 1'b1; op_b = op; arg_b = arg; end
    else   begin req_a = 1'b1; op_a = op; arg_a = arg; end
  endtask

  // Wait for a grant, then follow the command to its done pulse and check results
  task automatic run_cmd(input string tag, input bit exp_b, input bit drop);
    int          k;
    int          bc;
    int          steps;
    int          exp_lat;
    int          exp_steps;
    int          exp_bc;
    int unsigned q;
    bit          exp_wrap;
    logic [1:0]  op;
    int unsigned arg;
    k = 0;
    while (!(ack_a || ack_b) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!(ack_a || ack_b)) begin
      check({tag, "_ack_timeout"}, 0, 1);
      return;
    end
    check({tag, "_grant_b"}, 32'(ack_b), 32'(exp_b));
    check({tag, "_busy"}, 32'(busy), 1);
    op  = exp_b ? op_b : op_a;
    arg = exp_b ? 32'(arg_b) : 32'(arg_a);
    q = model_q;
    exp_wrap = 1'b0;
    exp_bc = 0;
    case (op)
      2'b00: begin q = 0; exp_lat = 2; exp_steps = 0; exp_bc = 1; end
      2'b01: begin exp_steps = (q != arg) ? 1 : 0; q = arg; exp_lat = 2; end
      2'b10: begin
        for (int i = 0; i < int'(arg); i++) begin
          if (q == 255) exp_wrap = 1'b1;
          q = (q + 1) % 256;
        end
        exp_lat = int'(arg) + 2; exp_steps = int'(arg);
      end
      default: begin
        for (int i = 0; i < int'(arg); i++) begin
          if (q == 0) exp_wrap = 1'b1;
          q = (q + 255) % 256;
        end
        exp_lat = int'(arg) + 2; exp_steps = int'(arg);
      end
    endcase
    favour_b = !exp_b;
    bc    = int'(bank_clear);
    steps = (t_out != '0) ? 1 : 0;
    if (drop) begin
      if (exp_b) req_b = 1'b0;
      else       req_a = 1'b0;
    end
    @(negedge clk);
    k = 1;
    check({tag, "_ack_1cycle"}, 32'(ack_a | ack_b), 0);
    while (!done && k < 400) begin
      bc += int'(bank_clear);
      steps += (t_out != '0) ? 1 : 0;
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    // done is sampled on the edge that lies exp_lat cycles after the grant edge
    check({tag, "_latency"}, 32'(k), 32'(exp_lat - 1));
    check({tag, "_q"}, 32'(q_bank), q);
    check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    check({tag, "_owner"}, 32'(owner), 32'(exp_b));
    check({tag, "_bank_clear"}, 32'(bc), 32'(exp_bc));
    check({tag, "_steps"}, 32'(steps), 32'(exp_steps));
    model_q = q;
    @(negedge clk);
    check({tag, "_done_1cycle"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_ack_a", 32'(ack_a), 0);
    check("rst_ack_b", 32'(ack_b), 0);
    check("rst_bank_clear", 32'(bank_clear), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_t", 32'(t_out), 0);
    clear = 1'b0;
    @(negedge clk);

    set_req(0, 2'b01, 8'hA5); run_cmd("load_a5", 0, 1);
    set_req(0, 2'b01, 8'hFD); run_cmd("load_fd", 0, 1);
    set_req(0, 2'b10, 8'd5);  run_cmd("up5_wrap", 0, 1);
    set_req(1, 2'b01, 8'h02); run_cmd("load_02", 1, 1);
    set_req(0, 2'b11, 8'd2);  run_cmd("down2", 0, 1);
    set_req(0, 2'b11, 8'd0);  run_cmd("down0", 0, 1);
    set_req(0, 2'b01, 8'h3C); run_cmd("load_3c", 0, 1);
    set_req(1, 2'b00, 8'h00); run_cmd("clear_b", 1, 1);

    // Both held high: grants must alternate, starting with A after B's CLEAR
    set_req(0, 2'b01, 8'h11);
    set_req(1, 2'b01, 8'h22);
    run_cmd("rr1_a", 0, 0);
    run_cmd("rr2_b", 1, 0);
    run_cmd("rr3_a", 0, 0);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);

    // Reset in the middle of UP 10, after four steps
    set_req(1, 2'b01, 8'h10); run_cmd("pre_abort", favour_b, 1);
    set_req(0, 2'b10, 8'd10);
    k = 0;
    while (!ack_a && k < 50) begin @(negedge clk); k++; end
    check("abort_ack", 32'(ack_a), 1);
    req_a = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_t", 32'(t_out), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    check("abort_q", 32'(q_bank), 32'h14);
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
      check("abort_q_frozen", 32'(q_bank), 32'h14);
    end
    check("abort_owner", 32'(owner), 0);
    check("abort_wrap", 32'(wrap), 0);
    model_q = 32'h14;
    favour_b = 1'b0;
    set_req(1, 2'b10, 8'd3); run_cmd("after_abort", 1, 1);

    // Random traffic: single and contending requests, biased toward boundary values
    for (int it = 0; it < 40; it++) begin
      int unsigned pat;
      pat = $urandom_range(0, 2);
      for (int s = 0; s < 2; s++) begin
        logic [1:0]       op;
        logic [WIDTH-1:0] arg;
        op = 2'($urandom_range(0, 3));
        if (op == 2'b01) begin
          if ($urandom_range(0, 1) == 1)
            arg = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(252, 255)) : 8'($urandom_range(0, 3));
          else
            arg = 8'($urandom);
        end else begin
          arg = 8'($urandom_range(0, 12));
        end
        if ((pat == 0 && s == 0) || (pat == 1 && s == 1) || pat == 2) set_req(s == 1, op, arg);
      end
      if (pat == 2) begin
        run_cmd("rnd_both1", favour_b, 1);
        run_cmd("rnd_both2", favour_b, 1);
      end else begin
        run_cmd("rnd_single", pat == 1, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
